// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the 7-segment scan controller
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_GAP = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Ceiling log2, never below 1 so every counter/index has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - register-side controls and display pins of the scan controller
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   wr_data;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      lzs_en;
    logic [NUM_DIGITS-1:0]     an_n;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic                      frame_done;

    modport master (
        output enable, load, wr_data, blank_mask, dp_mask, lzs_en,
        input  an_n, seg_n, dp_n, frame_done
    );

    modport slave (
        input  enable, load, wr_data, blank_mask, dp_mask, lzs_en,
        output an_n, seg_n, dp_n, frame_done
    );
endinterface

// File: rtl/hex_seg_dec.sv
// rtl/hex_seg_dec.sv - hex nibble to active-low 7-segment pattern, bit 6 = a ... bit 0 = g
module hex_seg_dec (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);
    always_comb begin
        seg_n = 7'b1111111;
        case (hex)
            4'h0: seg_n = 7'b0000001;
            4'h1: seg_n = 7'b1001111;
            4'h2: seg_n = 7'b0010010;
            4'h3: seg_n = 7'b0000110;
            4'h4: seg_n = 7'b1001100;
            4'h5: seg_n = 7'b0100100;
            4'h6: seg_n = 7'b0100000;
            4'h7: seg_n = 7'b0001111;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0000100;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b1100000;
            4'hC: seg_n = 7'b0110001;
            4'hD: seg_n = 7'b1000010;
            4'hE: seg_n = 7'b0110000;
            4'hF: seg_n = 7'b0111000;
            default: seg_n = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl_scan_timer.sv
// rtl/seg_scan_ctrl_scan_timer.sv - shared ON/GAP phase counter with terminal-count flag
module scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan of a double-buffered hex word onto shared 7-seg pins
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = clog2((TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int WW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0]         ON_LIMIT  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]         GAP_LIMIT = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);

    scan_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, idx_next;
    logic [WW-1:0]         pending_q, active_q, word_next;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d, dec_seg, shown_seg;
    logic                  dp_q, dp_d, fd_q, fd_d;
    logic                  wrap, all_zero, suppress, tmr_clear, tc;
    logic [3:0]            dec_hex;

    scan_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (bus.enable),
        .limit  ((state_q == ST_ON) ? ON_LIMIT : GAP_LIMIT),
        .tc     (tc)
    );

    hex_seg_dec u_dec (
        .hex   (dec_hex),
        .seg_n (dec_seg)
    );

    // Segment data for the digit about to light; at a frame wrap the freshly
    // committed word is decoded so digit 0 never shows the stale buffer.
    always_comb begin
        idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        wrap      = (idx_next == '0);
        word_next = wrap ? (bus.load ? bus.wr_data : pending_q) : active_q;
        dec_hex   = word_next[{idx_next, 2'b00} +: 4];
        all_zero  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_next) && word_next[i*4 +: 4] != 4'd0) all_zero = 1'b0;
        end
        suppress  = bus.lzs_en && !wrap && all_zero;
        shown_seg = (bus.blank_mask[idx_next] || suppress) ? SEG_OFF : dec_seg;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        fd_d      = 1'b0;
        tmr_clear = 1'b0;
        if (!bus.enable) begin
            state_d   = ST_GAP;
            idx_d     = LAST_IDX;
            an_d      = '1;
            seg_d     = SEG_OFF;
            dp_d      = 1'b1;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (tc) begin
                        state_d   = ST_GAP;
                        tmr_clear = 1'b1;
                        an_d      = '1;
                        seg_d     = SEG_OFF;
                        dp_d      = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tc) begin
                        state_d   = ST_ON;
                        tmr_clear = 1'b1;
                        idx_d     = idx_next;
                        an_d      = ~(DIG_ONE << idx_next);
                        seg_d     = shown_seg;
                        dp_d      = ~bus.dp_mask[idx_next];
                        fd_d      = wrap;
                    end
                end
                default: state_d = ST_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_GAP;
            idx_q     <= LAST_IDX;
            pending_q <= '0;
            active_q  <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
            if (bus.load) pending_q <= bus.wr_data;
            if (fd_d) active_q <= word_next;
        end
    end

    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_done = fd_q;
endmodule
